loopback_buffer: RTL and testbench

Single-clock, first-word-fall-through-free synchronous FIFO that buffers 32-bit words between the slave-FIFO read path (FX3 → FPGA) and the slave-FIFO write path (FPGA → FX3) of the loopback datapath. The read-side state machine pushes each captured DQ word. The write-side state machine pops one word per SLWR cycle. A flush pulse empties the buffer between loopback transactions. It also reports occupancy and sticky error flags so the loopback controller and LEDs can detect framing faults.

---
 rtl/fx3_pkg.sv | 18 +
 rtl/loopback_buffer_ram.sv | 34 +++
 rtl/loopback_buffer.sv | 120 ++++++++++++
 tb/tb_loopback_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_pkg.sv
// Shared FX3 slave-FIFO constants for the loopback datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fx3_pkg;

    // Width of the FX3 DQ bus.
    localparam int FX3_DATA_W = 32;

    // Default number of words buffered between the read and write paths.
    localparam int LOOPBACK_DEPTH = 1024;

    // Slave-FIFO socket addresses driven on the A[1:0] pins by the controller.
    typedef enum logic [1:0] {
        FX3_SOCK_WRITE = 2'b00,
        FX3_SOCK_READ  = 2'b11
    } fx3_sock_e;

endpackage

// File: rtl/loopback_buffer_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port, no reset.
// Latency: read data appears one cycle after rd_en.
// Backpressure: none; the caller gates wr_en/rd_en.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_en/rd_addr read request; rd_dat registered read data.
module loopback_buffer_ram
    import fx3_pkg::*;
#(
    parameter int WIDTH = FX3_DATA_W,
    parameter int DEPTH = LOOPBACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write on an address collision: when the buffer is full and
    // both ports hit the same entry, the pop must see the oldest word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/loopback_buffer.sv
// Synchronous FIFO between the slave-FIFO read path and write path of the loopback.
// Latency: pop-to-dout 1 cycle; push-to-poppable 1 cycle; status registered (1 cycle).
// Backpressure: push dropped when full (unless popping) -> sticky overflow; pop when empty -> sticky underflow.
// Ports: fifo_clk/reset_; din+push write side; pop -> dout/dout_valid read side; fifo_flush clear;
//        fifo_full/fifo_empty/almost_full/count status; overflow/underflow sticky errors.
module loopback_buffer
    import fx3_pkg::*;
#(
    parameter int WIDTH       = FX3_DATA_W,
    parameter int DEPTH       = LOOPBACK_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                     fifo_clk,
    input  logic                     reset_,
    input  logic [WIDTH-1:0]         din,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     fifo_flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] ram_rd_dat;
    logic             pop_ok;
    logic             push_ok;
    logic             ram_wr_en;
    logic             ram_rd_en;
    // The RAM output register has no reset; this flag masks it to zero until
    // the first real pop so dout still reads 0 out of reset.
    logic             dout_loaded;

    always_comb begin
        pop_ok    = pop && !fifo_empty;
        // A full buffer can still take a word if one leaves on the same edge.
        push_ok   = push && (!fifo_full || pop_ok);
        ram_wr_en = push_ok && !fifo_flush;
        ram_rd_en = pop_ok && !fifo_flush;

        count_nxt = count;
        if (fifo_flush) begin
            count_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            count_nxt = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    loopback_buffer_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (fifo_clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wptr),
        .wr_dat  (din),
        .rd_en   (ram_rd_en),
        .rd_addr (rptr),
        .rd_dat  (ram_rd_dat)
    );

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            almost_full <= 1'b0;
            dout_valid  <= 1'b0;
            dout_loaded <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            fifo_full   <= (count_nxt == CW'(DEPTH));
            fifo_empty  <= (count_nxt == '0);
            almost_full <= (count_nxt >= CW'(AFULL_LEVEL));
            if (fifo_flush) begin
                // dout (and dout_loaded) deliberately keep their value.
                wptr       <= '0;
                rptr       <= '0;
                dout_valid <= 1'b0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (ram_wr_en) begin
                    wptr <= wptr + AW'(1);
                end
                if (ram_rd_en) begin
                    rptr        <= rptr + AW'(1);
                    dout_loaded <= 1'b1;
                end
                dout_valid <= ram_rd_en;
                if (push && !push_ok) begin
                    overflow <= 1'b1;
                end
                if (pop && !pop_ok) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    assign dout = dout_loaded ? ram_rd_dat : '0;

endmodule

// File: tb/tb_loopback_buffer.sv
// Directed self-checking bench for loopback_buffer (default 32 x 1024).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises overflow, underflow, flush and async reset paths.
module tb_loopback_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int CW    = 11;

    logic             fifo_clk = 1'b0;
    logic             reset_;
    logic [WIDTH-1:0] din;
    logic             push;
    logic             pop;
    logic             fifo_flush;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 fifo_clk = ~fifo_clk;

    loopback_buffer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (DEPTH - 4)
    ) dut (
        .fifo_clk    (fifo_clk),
        .reset_      (reset_),
        .din         (din),
        .push        (push),
        .pop         (pop),
        .fifo_flush  (fifo_flush),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", fifo_full); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", almost_full); end
        n_cmp++; if (count !== 11'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b want 0", underflow); end
        reset_ = 1'b1;
        tick();
        n_cmp++; if (count !== 11'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: count %0d empty %b want 0/1", count, fifo_empty); end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            din = i; push = 1'b1;
            tick();
        end
        push = 1'b0;
        n_cmp++; if (count !== 11'd4) begin n_fail++; $display("FAIL basic_count4: got %0d want 4", count); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty: got %b want 0", fifo_empty); end
        for (int i = 1; i <= 4; i++) begin
            pop = 1'b1;
            tick();
            n_cmp++; if (dout !== 32'(i)) begin n_fail++; $display("FAIL basic_dout[%0d]: got %h want %h", i, dout, 32'(i)); end
            n_cmp++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_dv[%0d]: got %b want 1", i, dout_valid); end
            n_cmp++; if (count !== 11'(4 - i)) begin n_fail++; $display("FAIL basic_count[%0d]: got %0d want %0d", i, count, 4 - i); end
        end
        pop = 1'b0;
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_drop: got %b want 0", dout_valid); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (dout !== 32'd4) begin n_fail++; $display("FAIL basic_dout_hold: got %h want 4", dout); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            din = 32'h1000_0000 + i; push = 1'b1;
            tick();
            if (i == DEPTH - 6) begin
                n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL afull_below: got %b want 0 at count %0d", almost_full, count); end
            end
            if (i == DEPTH - 5) begin
                n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL afull_at: got %b want 1 at count %0d", almost_full, count); end
            end
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
        din = 32'hDEAD_BEEF; push = 1'b1;
        tick();
        push = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (count !== 11'd1024) begin n_fail++; $display("FAIL ovf_count: got %0d want 1024", count); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_hold: got %b want 1", fifo_full); end
        pop = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_cmp++; if (dout !== 32'h1000_0000 + i) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, dout, 32'h1000_0000 + i); end
        end
        pop = 1'b0;
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_no_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_full_pushpop();
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf_clear: got %b want 0", overflow); end
        // Stream 1019 words through so both pointers sit at 1019 before filling.
        for (int i = 0; i <= DEPTH - 5; i++) begin
            din = i; push = (i < DEPTH - 5); pop = (i > 0);
            tick();
        end
        push = 1'b0; pop = 1'b0;
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL prime_empty: got %b want 1", fifo_empty); end
        for (int i = 0; i < DEPTH; i++) begin
            din = 32'h3000_0000 + i; push = 1'b1;
            tick();
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b want 1", fifo_full); end
        pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 32'h4000_0000 + k;
            tick();
            n_cmp++; if (dout !== 32'h3000_0000 + k) begin n_fail++; $display("FAIL pp_dout[%0d]: got %h want %h", k, dout, 32'h3000_0000 + k); end
            n_cmp++; if (count !== 11'd1024) begin n_fail++; $display("FAIL pp_count[%0d]: got %0d want 1024", k, count); end
            n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow[%0d]: got %b want 0", k, overflow); end
        end
        push = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [31:0] exp;
            exp = (k < DEPTH - 10) ? 32'h3000_0000 + 10 + k : 32'h4000_0000 + (k - (DEPTH - 10));
            tick();
            n_cmp++; if (dout !== exp) begin n_fail++; $display("FAIL pp_drain[%0d]: got %h want %h", k, dout, exp); end
        end
        pop = 1'b0;
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_empty_pushpop();
        din = 32'hA5A5_A5A5; push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL ep_underflow: got %b want 1", underflow); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ep_dv: got %b want 0", dout_valid); end
        n_cmp++; if (count !== 11'd1) begin n_fail++; $display("FAIL ep_count: got %0d want 1", count); end
        n_cmp++; if (dout !== 32'h4000_0009) begin n_fail++; $display("FAIL ep_no_bypass: got %h want 40000009", dout); end
        tick();
        pop = 1'b0;
        n_cmp++; if (dout !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ep_next_pop: got %h want a5a5a5a5", dout); end
        n_cmp++; if (dout_valid !== 1'b1 || count !== 11'd0) begin n_fail++; $display("FAIL ep_after: dv %b count %0d want 1/0", dout_valid, count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 100; i++) begin
            din = 32'h6000_0000 + i; push = 1'b1;
            tick();
        end
        n_cmp++; if (count !== 11'd100) begin n_fail++; $display("FAIL fl_count100: got %0d want 100", count); end
        din = 32'hFFFF_FFFF; fifo_flush = 1'b1; pop = 1'b1;
        tick();
        fifo_flush = 1'b0; push = 1'b0; pop = 1'b0;
        n_cmp++; if (count !== 11'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", count); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL fl_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL fl_flags: ovf %b unf %b want 0/0", overflow, underflow); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL fl_dv: got %b want 0", dout_valid); end
        n_cmp++; if (dout !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fl_dout_hold: got %h want a5a5a5a5", dout); end
        din = 32'h1234_5678; push = 1'b1;
        tick();
        push = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++; if (dout !== 32'h1234_5678) begin n_fail++; $display("FAIL fl_first_word: got %h want 12345678", dout); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) begin
            din = 32'h5000_0000 + i; push = 1'b1;
            tick();
        end
        push = 1'b0; pop = 1'b1;
        tick();
        n_cmp++; if (dout !== 32'h5000_0000 || count !== 11'd49) begin n_fail++; $display("FAIL rm_pre: dout %h count %0d want 50000000/49", dout, count); end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 reset_ = 1'b0;
        #1;
        n_cmp++; if (dout !== 32'h0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL rm_dout: dout %h dv %b want 0/0", dout, dout_valid); end
        n_cmp++; if (count !== 11'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rm_count: count %0d empty %b want 0/1", count, fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rm_status: full %b af %b ovf %b unf %b want 0000", fifo_full, almost_full, overflow, underflow); end
        tick();
        pop = 1'b0;
        reset_ = 1'b1;
        tick();
        din = 32'hCAFE_F00D; push = 1'b1;
        tick();
        push = 1'b0;
        n_cmp++; if (count !== 11'd1) begin n_fail++; $display("FAIL rm_push_count: got %0d want 1", count); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++; if (dout !== 32'hCAFE_F00D || dout_valid !== 1'b1) begin n_fail++; $display("FAIL rm_roundtrip: dout %h dv %b want cafef00d/1", dout, dout_valid); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rm_empty: got %b want 1", fifo_empty); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0; din = '0; push = 1'b0; pop = 1'b0; fifo_flush = 1'b0;
        repeat (2) @(posedge fifo_clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
